// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter generator.
// Holds the default PC width and reset vector and the next-PC select enum.
package pc_pkg;

   localparam int PC_ADDR_W = 10;
   localparam int PC_RESET  = 0;

   typedef enum logic [2:0] {
      NPC_SEQ,
      NPC_REDIR,
      NPC_CALL,
      NPC_RET,
      NPC_CALLRET,
      NPC_HOLD
   } npc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full.
// Ports: clk, rst (async, active-high); push/pop/replace strobes with wdata;
//        top (current top entry), empty and full (derived from the count).
module pc_ras
   import pc_pkg::*;
#(
   parameter int ADDR_W = PC_ADDR_W,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              replace,
   input  logic [ADDR_W-1:0] wdata,
   output logic [ADDR_W-1:0] top,
   output logic              empty,
   output logic              full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  ptr;
   logic [PTR_W-1:0]  ptr_up;
   logic [PTR_W-1:0]  ptr_dn;
   logic [CNT_W-1:0]  count;

   // ptr names the top entry; the pointer simply wraps, so a push into a
   // full stack lands on the oldest slot while count saturates.
   assign ptr_up = ptr + 1'b1;
   assign ptr_dn = ptr - 1'b1;
   assign top    = mem[ptr];
   assign empty  = (count == '0);
   assign full   = (count == CNT_W'(DEPTH));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr   <= '0;
         count <= '0;
      end else if (push) begin
         ptr <= ptr_up;
         if (!full) begin
            count <= count + 1'b1;
         end
      end else if (pop && !empty) begin
         ptr   <= ptr_dn;
         count <= count - 1'b1;
      end
   end

   // Entry contents need no reset: count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[ptr_up] <= wdata;
      end else if (replace) begin
         mem[ptr] <= wdata;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: PC register, next-PC priority and sticky
// underflow flag, with an optional return-address stack (macro PC_RAS_EN).
// Ports: clk, rst (async, active-high), en (stall when low);
//        redir_valid/redir_pc, call_valid/call_pc, ret_valid requests;
//        pc (registered), pc_4 (pc+1), ras_empty, ras_full, ras_underflow.
module pc_gen
   import pc_pkg::*;
#(
   parameter int              ADDR_W    = PC_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PC_RESET),
   parameter int              RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              redir_valid,
   input  logic [ADDR_W-1:0] redir_pc,
   input  logic              call_valid,
   input  logic [ADDR_W-1:0] call_pc,
   input  logic              ret_valid,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_4,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_underflow
);

   npc_sel_e          sel;
   logic [ADDR_W-1:0] pc_nxt;
   logic [ADDR_W-1:0] ras_top;
   logic              ras_push;
   logic              ras_pop;
   logic              ras_repl;
   logic              uf_set;

   assign pc_4 = pc + 1'b1;

   always_comb begin
      sel = NPC_SEQ;
      if (!en) begin
         sel = NPC_HOLD;
      end else if (redir_valid) begin
         sel = NPC_REDIR;
      end else if (ret_valid && call_valid) begin
         sel = NPC_CALLRET;
      end else if (ret_valid) begin
         sel = NPC_RET;
      end else if (call_valid) begin
         sel = NPC_CALL;
      end
   end

   always_comb begin
      pc_nxt   = pc;
      ras_push = 1'b0;
      ras_pop  = 1'b0;
      ras_repl = 1'b0;
      uf_set   = 1'b0;
      unique case (sel)
         NPC_HOLD: begin
            pc_nxt = pc;
         end
         NPC_REDIR: begin
            pc_nxt = redir_pc;
         end
         // Call+ret in one slot: jump to the top and leave our own
         // return address in its place, so depth is unchanged.
         NPC_CALLRET: begin
            if (ras_empty) begin
               pc_nxt   = pc_4;
               ras_push = 1'b1;
               uf_set   = 1'b1;
            end else begin
               pc_nxt   = ras_top;
               ras_repl = 1'b1;
            end
         end
         NPC_RET: begin
            if (ras_empty) begin
               pc_nxt = pc_4;
               uf_set = 1'b1;
            end else begin
               pc_nxt  = ras_top;
               ras_pop = 1'b1;
            end
         end
         NPC_CALL: begin
            pc_nxt   = call_pc;
            ras_push = 1'b1;
         end
         default: begin
            pc_nxt = pc_4;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc            <= RESET_PC;
         ras_underflow <= 1'b0;
      end else begin
         pc <= pc_nxt;
         if (uf_set) begin
            ras_underflow <= 1'b1;
         end
      end
   end

`ifdef PC_RAS_EN

   pc_ras #(
      .ADDR_W (ADDR_W),
      .DEPTH  (RAS_DEPTH)
   ) u_ras (
      .clk     (clk),
      .rst     (rst),
      .push    (ras_push),
      .pop     (ras_pop),
      .replace (ras_repl),
      .wdata   (pc_4),
      .top     (ras_top),
      .empty   (ras_empty),
      .full    (ras_full)
   );

`else

   // No stack: every return sees an empty RAS and calls push nothing.
   localparam int unused_depth = RAS_DEPTH;

   logic unused_ras;

   assign ras_top    = '0;
   assign ras_empty  = 1'b1;
   assign ras_full   = 1'b0;
   assign unused_ras = ^{ras_push, ras_pop, ras_repl};

`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed plan steps then random traffic,
// compared against a queue-based reference model of the PC and RAS.
module tb_pc_gen;

   localparam int         AW    = 10;
   localparam logic [9:0] RPC   = 10'h100;
   localparam int         DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          redir_valid = 1'b0;
   logic [AW-1:0] redir_pc = '0;
   logic          call_valid = 1'b0;
   logic [AW-1:0] call_pc = '0;
   logic          ret_valid = 1'b0;
   logic [AW-1:0] pc;
   logic [AW-1:0] pc_4;
   logic          ras_empty;
   logic          ras_full;
   logic          ras_underflow;

   always #5 clk = ~clk;

   pc_gen #(
      .ADDR_W    (AW),
      .RESET_PC  (RPC),
      .RAS_DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .redir_valid   (redir_valid),
      .redir_pc      (redir_pc),
      .call_valid    (call_valid),
      .call_pc       (call_pc),
      .ret_valid     (ret_valid),
      .pc            (pc),
      .pc_4          (pc_4),
      .ras_empty     (ras_empty),
      .ras_full      (ras_full),
      .ras_underflow (ras_underflow)
   );

   int n_assert = 0;
   int n_fail   = 0;

   logic [AW-1:0] m_pc;
   logic          m_uf;
   logic [AW-1:0] m_ras [$];

   task automatic model_reset();
      m_pc = RPC;
      m_uf = 1'b0;
      m_ras.delete();
   endtask

   // Stack modelled as a list of return addresses, newest at the back.
   task automatic model_step(input logic e, input logic rv,
                             input logic [AW-1:0] rp, input logic cv,
                             input logic [AW-1:0] cp, input logic tv);
      logic [AW-1:0] nx;
      logic [AW-1:0] t;
      nx = m_pc + 10'd1;
      if (!e) begin
         return;
      end
      if (rv) begin
         m_pc = rp;
      end else if (tv && cv) begin
`ifdef PC_RAS_EN
         if (m_ras.size() > 0) begin
            t = m_ras[m_ras.size()-1];
            m_ras[m_ras.size()-1] = nx;
            m_pc = t;
         end else begin
            m_ras.push_back(nx);
            m_pc = nx;
            m_uf = 1'b1;
         end
`else
         m_pc = nx;
         m_uf = 1'b1;
`endif
      end else if (tv) begin
         if (m_ras.size() > 0) begin
            t = m_ras.pop_back();
            m_pc = t;
         end else begin
            m_pc = nx;
            m_uf = 1'b1;
         end
      end else if (cv) begin
`ifdef PC_RAS_EN
         m_ras.push_back(nx);
         if (m_ras.size() > DEPTH) begin
            t = m_ras.pop_front();
         end
`endif
         m_pc = cp;
      end else begin
         m_pc = nx;
      end
   endtask

   task automatic check(input string tag);
      logic [AW-1:0] e4;
      logic          ee;
      logic          ef;
      e4 = m_pc + 10'd1;
      ee = (m_ras.size() == 0);
      ef = (m_ras.size() == DEPTH);
      n_assert++;
      assert (pc === m_pc) else begin
         n_fail++;
         $error("FAIL %s pc: got %h expected %h", tag, pc, m_pc);
      end
      n_assert++;
      assert (pc_4 === e4) else begin
         n_fail++;
         $error("FAIL %s pc_4: got %h expected %h", tag, pc_4, e4);
      end
      n_assert++;
      assert (ras_empty === ee) else begin
         n_fail++;
         $error("FAIL %s ras_empty: got %b expected %b",
                tag, ras_empty, ee);
      end
      n_assert++;
      assert (ras_full === ef) else begin
         n_fail++;
         $error("FAIL %s ras_full: got %b expected %b",
                tag, ras_full, ef);
      end
      n_assert++;
      assert (ras_underflow === m_uf) else begin
         n_fail++;
         $error("FAIL %s ras_underflow: got %b expected %b",
                tag, ras_underflow, m_uf);
      end
   endtask

   task automatic cycle(input logic e, input logic rv,
                        input logic [AW-1:0] rp, input logic cv,
                        input logic [AW-1:0] cp, input logic tv,
                        input string tag);
      en          = e;
      redir_valid = rv;
      redir_pc    = rp;
      call_valid  = cv;
      call_pc     = cp;
      ret_valid   = tv;
      @(posedge clk);
      model_step(e, rv, rp, cv, cp, tv);
      #1;
      check(tag);
   endtask

   task automatic seq(input string tag);
      cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, tag);
   endtask

   task automatic redir(input logic [AW-1:0] a, input string tag);
      cycle(1'b1, 1'b1, a, 1'b0, '0, 1'b0, tag);
   endtask

   task automatic call(input logic [AW-1:0] a, input string tag);
      cycle(1'b1, 1'b0, '0, 1'b1, a, 1'b0, tag);
   endtask

   task automatic ret(input string tag);
      cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, tag);
   endtask

   initial begin
      model_reset();
      rst = 1'b1;
      #12;
      check("reset");
      rst = 1'b0;

      seq("seq1");
      seq("seq2");
      seq("seq3");

      redir(10'h3FF, "to_3ff");
      seq("wrap");
      cycle(1'b0, 1'b1, 10'h155, 1'b1, 10'h0AA, 1'b1, "stall1");
      cycle(1'b0, 1'b0, '0, 1'b1, 10'h0AA, 1'b0, "stall2");

      redir(10'h020, "to_020");
      call(10'h080, "call_080");
      seq("seq_081");
      ret("ret_021");

      redir(10'h040, "to_040");
      call(10'h100, "call_a1");
      call(10'h110, "call_a2");
      call(10'h120, "call_a3");
      call(10'h130, "call_a4");
      call(10'h140, "call_a5");
      ret("ret_a5");
      ret("ret_a4");
      ret("ret_a3");
      ret("ret_a2");
      ret("ret_underflow");

      call(10'h180, "pre_prio");
      cycle(1'b1, 1'b1, 10'h200, 1'b1, 10'h333, 1'b1, "redir_prio");

      redir(10'h3FF, "to_3ff_b");
      call(10'h010, "call_wrap");
      ret("ret_wrap");

      call(10'h050, "call_050");
      cycle(1'b1, 1'b0, '0, 1'b1, 10'h060, 1'b1, "callret");
      ret("ret_after_cr");

      call(10'h070, "call_070");
      call(10'h090, "call_090");
      cycle(1'b0, 1'b0, '0, 1'b1, 10'h0F0, 1'b1, "stall_pre_rst");
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check("async_rst");
      rst = 1'b0;
      seq("post_rst");

      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 7) != 0),
               ($urandom_range(0, 9) == 0),
               AW'($urandom),
               ($urandom_range(0, 2) == 0),
               AW'($urandom),
               ($urandom_range(0, 3) == 0),
               "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
